data_memory_arbiter: RTL and testbench

Two-port round-robin arbiter and access sequencer placed in front of the single-port `DataMemory`. It lets two masters share the one memory port: port 0 is the CPU load/store path and port 1 is the debug/DMA loader. It accepts a held request/acknowledge handshake from each master and drives the memory's `MemWrite`/`MemRead`/`Address`/`WriteData` for exactly one cycle per transaction. It captures `ReadData` into a per-port register and returns a one-cycle acknowledge.

---
 rtl/data_memory_arbiter.sv | 118 +++++++++++
 tb/tb_data_memory_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU path (port 0)
// and the debug/DMA loader (port 1); one memory cycle per granted transaction.
module data_memory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    Idle   = 2'd0,
    Access = 2'd1,
    Done   = 2'd2
  } stateT;

  stateT                 state;
  logic                  lastGrant;
  logic                  curPort;
  logic                  curWe;
  logic                  pickOne;
  logic [1:0]            weVec;
  logic [ADDR_WIDTH-1:0] addrArr  [2];
  logic [DATA_WIDTH-1:0] wdataArr [2];
  logic [DATA_WIDTH-1:0] rdataArr [2];
  logic                  ackArr   [2];

  assign weVec       = {m1_we, m0_we};
  assign addrArr[0]  = m0_addr;
  assign addrArr[1]  = m1_addr;
  assign wdataArr[0] = m0_wdata;
  assign wdataArr[1] = m1_wdata;

  // Port 1 wins when it is the only requester, or on a tie when port 0 had the last grant.
  assign pickOne = m1_req & (~m0_req | ~lastGrant);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= Idle;
      lastGrant <= 1'b1;
      curPort   <= 1'b0;
      curWe     <= 1'b0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        Idle: begin
          if (m0_req || m1_req) begin
            curPort   <= pickOne;
            curWe     <= weVec[pickOne];
            mem_addr  <= addrArr[pickOne];
            mem_wdata <= wdataArr[pickOne];
            mem_write <= weVec[pickOne];
            mem_read  <= ~weVec[pickOne];
            state     <= Access;
          end
        end
        Access: begin
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          state     <= Done;
        end
        Done: begin
          lastGrant <= curPort;
          state     <= Idle;
        end
        default: begin
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          state     <= Idle;
        end
      endcase
    end
  end

  // Per-port completion: ack is high only in DONE, read data captured as ACCESS closes.
  for (genvar gi = 0; gi < 2; gi++) begin : gPort
    logic hit;
    assign hit = (state == Access) && (curPort == 1'(gi));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ackArr[gi]   <= 1'b0;
        rdataArr[gi] <= '0;
      end else begin
        ackArr[gi] <= hit;
        if (hit && !curWe) begin
          rdataArr[gi] <= mem_rdata;
        end
      end
    end
  end

  assign m0_ack   = ackArr[0];
  assign m1_ack   = ackArr[1];
  assign m0_rdata = rdataArr[0];
  assign m1_rdata = rdataArr[1];

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and random
// traffic from two legal masters, checked against a transaction-level model.
module tb_data_memory_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_write, mem_read;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  data_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory attached to the arbiter: combinational read, write at the edge.
  logic [31:0] memArr [256] = '{default: 32'h0};
  always @(posedge clk) if (mem_write) memArr[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = mem_read ? memArr[mem_addr[7:0]] : '0;

  int nCompared = 0;
  int nMismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a granted transaction occupies the memory for the edge after its grant,
  // acks on the following one, and the arbiter samples requests again one edge later.
  logic [31:0] refMem [256] = '{default: 32'h0};
  bit          mBusy, mPort, mWe, mLast;
  int          mEdge = 0, mGrantEdge = 0;
  logic [31:0] mAddr, mWdata;
  logic        eAck [2];
  logic        eWrite, eRead;
  logic [31:0] eAddr, eWdata;
  logic [31:0] eRd [2];

  task automatic modelReset();
    mBusy = 0; mLast = 1;
    eAck[0] = 0; eAck[1] = 0; eWrite = 0; eRead = 0;
    eAddr = 0; eWdata = 0; eRd[0] = 0; eRd[1] = 0;
  endtask

  task automatic modelEdge(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                           input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
    mEdge++;
    eAck[0] = 0; eAck[1] = 0; eWrite = 0; eRead = 0;
    if (mBusy && mEdge == mGrantEdge + 1) begin
      if (mWe) refMem[mAddr[7:0]] = mWdata;
      else     eRd[mPort] = refMem[mAddr[7:0]];
      eAck[mPort] = 1;
      mLast = mPort;
    end
    if (mBusy && mEdge == mGrantEdge + 2) begin
      mBusy = 0;
    end else if (!mBusy && (r0 || r1)) begin
      mPort  = (r0 && r1) ? ~mLast : r1;
      mWe    = mPort ? w1 : w0;
      mAddr  = mPort ? a1 : a0;
      mWdata = mPort ? d1 : d0;
      mBusy = 1; mGrantEdge = mEdge;
      eWrite = mWe; eRead = !mWe; eAddr = mAddr; eWdata = mWdata;
    end
  endtask

  task automatic checkAll();
    chk("m0_ack", 32'(m0_ack), 32'(eAck[0]));
    chk("m1_ack", 32'(m1_ack), 32'(eAck[1]));
    chk("mem_write", 32'(mem_write), 32'(eWrite));
    chk("mem_read", 32'(mem_read), 32'(eRead));
    chk("mem_addr", mem_addr, eAddr);
    chk("mem_wdata", mem_wdata, eWdata);
    chk("m0_rdata", m0_rdata, eRd[0]);
    chk("m1_rdata", m1_rdata, eRd[1]);
  endtask

  task automatic cycle();
    bit r0, w0, r1, w1;
    logic [31:0] a0, d0, a1, d1;
    r0 = m0_req; w0 = m0_we; a0 = m0_addr; d0 = m0_wdata;
    r1 = m1_req; w1 = m1_we; a1 = m1_addr; d1 = m1_wdata;
    @(posedge clk);
    #1;
    modelEdge(r0, w0, a0, d0, r1, w1, a1, d1);
    checkAll();
  endtask

  task automatic setPort(input bit p, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (p) begin m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; end
    else   begin m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; end
  endtask

  task automatic runTxn(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d);
    int ackAt = -1;
    int wr = 0;
    int rd = 0;
    setPort(p, 1, we, a, d);
    for (int k = 1; k <= 8 && ackAt < 0; k++) begin
      cycle();
      if (mem_write) wr++;
      if (mem_read) rd++;
      if (p ? m1_ack : m0_ack) ackAt = k;
    end
    chk("txn_ack_latency", 32'(ackAt), 32'd2);
    chk("txn_write_cycles", 32'(wr), we ? 32'd1 : 32'd0);
    chk("txn_read_cycles", 32'(rd), we ? 32'd0 : 32'd1);
    $display("txn port%0d we=%0d addr=%08h wdata=%08h ack_cycle=%0d rdata=%08h",
             p, we, a, d, ackAt, p ? m1_rdata : m0_rdata);
    setPort(p, 0, 0, 0, 0);
    cycle();
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRd0;
    logic [31:0] expRd1;
  } vecT;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecT vecs [7];
    int  ackCyc [$];
    int  ackPort [$];
    int  expCyc [4] = '{2, 5, 8, 11};
    int  expPort [4] = '{0, 1, 0, 1};
    bit  act [2];
    int  acks, rd;

    vecs[0] = '{0, 1, 32'h10, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[1] = '{0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[2] = '{1, 1, 32'h20, 32'h12345678, 32'hDEADBEEF, 32'h0};
    vecs[3] = '{0, 0, 32'h20, 32'h0,        32'h12345678, 32'h0};
    vecs[4] = '{1, 0, 32'h10, 32'h0,        32'h12345678, 32'hDEADBEEF};
    vecs[5] = '{1, 1, 32'h10, 32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF};
    vecs[6] = '{0, 0, 32'h10, 32'h0,        32'hCAFEF00D, 32'hDEADBEEF};

    reset = 0;
    setPort(0, 0, 0, 0, 0);
    setPort(1, 0, 0, 0, 0);

    // Reset held with random inputs: every output stays at zero.
    for (int i = 0; i < 5; i++) begin
      setPort(0, 1'($urandom), 1'($urandom), $urandom, $urandom);
      setPort(1, 1'($urandom), 1'($urandom), $urandom, $urandom);
      @(posedge clk);
      #1;
      chk("rst_m0_ack", 32'(m0_ack), 0);
      chk("rst_m1_ack", 32'(m1_ack), 0);
      chk("rst_mem_write", 32'(mem_write), 0);
      chk("rst_mem_read", 32'(mem_read), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_m0_rdata", m0_rdata, 0);
      chk("rst_m1_rdata", m1_rdata, 0);
    end
    setPort(0, 0, 0, 0, 0);
    setPort(1, 0, 0, 0, 0);
    reset = 1;
    modelReset();
    for (int i = 0; i < 4; i++) cycle();

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      runTxn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      chk("tbl_m0_rdata", m0_rdata, vecs[i].expRd0);
      chk("tbl_m1_rdata", m1_rdata, vecs[i].expRd1);
    end

    // Simultaneous continuous requests straight out of reset.
    reset = 0;
    @(posedge clk);
    #1;
    reset = 1;
    modelReset();
    setPort(0, 1, 0, 32'h10, 0);
    setPort(1, 1, 0, 32'h20, 0);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (m0_ack) begin ackCyc.push_back(k); ackPort.push_back(0); end
      if (m1_ack) begin ackCyc.push_back(k); ackPort.push_back(1); end
    end
    chk("alt_ack_count", 32'(ackCyc.size()), 32'd4);
    for (int i = 0; i < ackCyc.size() && i < 4; i++) begin
      $display("alt grant %0d: port%0d acked at cycle %0d", i, ackPort[i], ackCyc[i]);
      chk("alt_ack_port", 32'(ackPort[i]), 32'(expPort[i]));
      chk("alt_ack_cycle", 32'(ackCyc[i]), 32'(expCyc[i]));
    end
    setPort(0, 0, 0, 0, 0);
    setPort(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();

    // Random traffic from two masters that hold req until their ack.
    act[0] = 0; act[1] = 0;
    for (int c = 0; c < 430; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p]) begin
          if (c < 400 && $urandom_range(0, 3) != 0) begin
            setPort(1'(p), 1, 1'($urandom), 32'($urandom_range(0, 15)) << 2, $urandom);
            act[p] = 1;
          end else begin
            setPort(1'(p), 0, 1'($urandom), $urandom, $urandom);
          end
        end
      end
      cycle();
      if (m0_ack) act[0] = 0;
      if (m1_ack) act[1] = 0;
    end
    setPort(0, 0, 0, 0, 0);
    setPort(1, 0, 0, 0, 0);
    chk("rand_drained", {30'd0, act[1], act[0]}, 0);
    for (int i = 0; i < 3; i++) cycle();

    // Port 1 drops req during ACCESS: transaction still completes exactly once.
    setPort(1, 1, 0, 32'h20, 0);
    cycle();
    setPort(1, 0, 0, 0, 0);
    rd = mem_read ? 1 : 0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (m1_ack) acks++;
      if (mem_read) rd++;
    end
    $display("drop port1 read addr=00000020 acks=%0d reads=%0d rdata=%08h", acks, rd, m1_rdata);
    chk("drop_ack_count", 32'(acks), 32'd1);
    chk("drop_read_cycles", 32'(rd), 32'd1);

    // Reset during ACCESS of a write: memory keeps its old contents, no ack.
    runTxn(0, 1, 32'h30, 32'h11111111);
    setPort(0, 1, 1, 32'h30, 32'hA5A5A5A5);
    cycle();
    setPort(0, 0, 0, 0, 0);
    #2;
    reset = 0;
    #1;
    chk("midrst_mem_write", 32'(mem_write), 0);
    chk("midrst_m0_ack", 32'(m0_ack), 0);
    @(posedge clk);
    #1;
    reset = 1;
    modelReset();
    for (int i = 0; i < 6; i++) cycle();
    chk("midrst_mem_contents", memArr[8'h30], 32'h11111111);
    runTxn(0, 0, 32'h30, 0);
    chk("midrst_readback", m0_rdata, 32'h11111111);
    $display("reset-mid-access readback addr=00000030 rdata=%08h", m0_rdata);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
